// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB pipeline register, load extraction, result select
// and the retired-instruction counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mem_valid_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [1:0]       mem_wbsel_i,
  input  logic [2:0]       mem_funct3_i,
  input  logic [XLEN-1:0]  mem_alu_result_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic [XLEN-1:0]  mem_pc4_i,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  writedata,
  output logic             regwrite,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  logic             r_valid;
  logic             r_regwrite;
  logic [4:0]       r_rd;
  logic [1:0]       r_wbsel;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  r_pc4;
  logic [CNT_W-1:0] r_instret;
  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_wdata;

  // Little-endian lane pick; halfword lanes ignore addr[0], words ignore addr entirely.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  addr,
                                               input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (addr)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      2'd3:    b = data[31:24];
      default: b = 8'd0;
    endcase
    h = addr[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      default: res = data;
    endcase
    return res;
  endfunction

  // MEM/WB register and retire counter; stall freezes everything including flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= 5'd0;
      r_wbsel    <= 2'd0;
      r_funct3   <= 3'd0;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_instret  <= '0;
    end else if (!stall_i) begin
      r_valid    <= mem_valid_i & ~flush_i;
      r_regwrite <= mem_regwrite_i;
      r_rd       <= mem_rd_i;
      r_wbsel    <= mem_wbsel_i;
      r_funct3   <= mem_funct3_i;
      r_alu      <= mem_alu_result_i;
      r_rdata    <= mem_rdata_i;
      r_pc4      <= mem_pc4_i;
      if (r_valid) begin
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_instret <= r_instret;
      end
    end else begin
      r_valid    <= r_valid;
      r_instret  <= r_instret;
    end
  end

  // Result select, driven only from registered WB state.
  always_comb begin
    w_load  = load_extract(r_funct3, r_alu[1:0], r_rdata);
    w_wdata = r_alu;
    case (r_wbsel)
      2'b01:   w_wdata = w_load;
      2'b10:   w_wdata = r_pc4;
      default: w_wdata = r_alu;
    endcase
  end

  assign rd        = r_rd;
  assign writedata = w_wdata;
  assign regwrite  = r_valid & r_regwrite & (r_rd != 5'd0);
  assign wb_valid  = r_valid;
  assign instret   = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a field-level reference model.
module tb_wb_stage;
  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        mem_valid_i;
  logic        mem_regwrite_i;
  logic [4:0]  mem_rd_i;
  logic [1:0]  mem_wbsel_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_alu_result_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] mem_pc4_i;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        regwrite;
  logic        wb_valid;
  logic [63:0] instret;

  int n_tests;
  int n_fail;

  // reference model state
  bit          m_valid;
  bit          m_rw;
  int unsigned m_rd;
  logic [31:0] m_wd;
  logic [63:0] m_instret;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_regwrite_i(mem_regwrite_i),
    .mem_rd_i(mem_rd_i), .mem_wbsel_i(mem_wbsel_i), .mem_funct3_i(mem_funct3_i),
    .mem_alu_result_i(mem_alu_result_i), .mem_rdata_i(mem_rdata_i),
    .mem_pc4_i(mem_pc4_i), .rd(rd), .writedata(writedata), .regwrite(regwrite),
    .wb_valid(wb_valid), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_wd(input int unsigned wbsel, input int unsigned f3,
                                         input logic [31:0] alu, input logic [31:0] rdata,
                                         input logic [31:0] pc4);
    int unsigned a;
    int unsigned v;
    a = alu % 4;
    if (wbsel == 2) return pc4;
    if (wbsel != 1) return alu;
    case (f3)
      0: begin v = (rdata >> (8 * a)) % 256; return (v >= 128) ? (v + 32'hFFFF_FF00) : v; end
      4: return (rdata >> (8 * a)) % 256;
      1: begin v = (rdata >> (16 * (a / 2))) % 65536; return (v >= 32768) ? (v + 32'hFFFF_0000) : v; end
      5: return (rdata >> (16 * (a / 2))) % 65536;
      default: return rdata;
    endcase
  endfunction

  task automatic drive(input bit v, input bit rw, input int unsigned r, input int unsigned ws,
                       input int unsigned f3, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    mem_valid_i      = v;
    mem_regwrite_i   = rw;
    mem_rd_i         = 5'(r);
    mem_wbsel_i      = 2'(ws);
    mem_funct3_i     = 3'(f3);
    mem_alu_result_i = alu;
    mem_rdata_i      = rdata;
    mem_pc4_i        = pc4;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
  endtask

  // advance one clock, update the model from the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (!stall_i) begin
      if (m_valid) m_instret = m_instret + 64'd1;
      m_valid = mem_valid_i && !flush_i;
      m_rd    = mem_rd_i;
      m_rw    = mem_regwrite_i;
      m_wd    = ref_wd(mem_wbsel_i, mem_funct3_i, mem_alu_result_i, mem_rdata_i, mem_pc4_i);
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    bubble();
    m_valid = 0; m_rw = 0; m_rd = 0; m_wd = 32'd0; m_instret = 64'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (rd !== 5'd0 || writedata !== 32'd0 || regwrite !== 1'b0 || wb_valid !== 1'b0 || instret !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: rd=%0d wd=%h rw=%b v=%b ir=%0d, required all zero", rd, writedata, regwrite, wb_valid, instret);
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 5, 0, 0, 32'h0000_1234, 32'hAAAA_AAAA, 32'h0000_0008);
    tick();
    n_tests++;
    if (rd !== 5'd5 || writedata !== 32'h1234 || regwrite !== 1'b1 || instret !== 64'd0) begin
      n_fail++;
      $display("FAIL alu: rd=%0d wd=%h rw=%b ir=%0d, required 5 00001234 1 0", rd, writedata, regwrite, instret);
    end
    bubble();
    tick();
    n_tests++;
    if (instret !== 64'd1 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_retire: ir=%0d v=%b, required 1 0", instret, wb_valid);
    end
  endtask

  task automatic test_loads();
    logic [31:0] exp_tab [6];
    int unsigned f3_tab [6];
    int unsigned a_tab [6];
    f3_tab = '{0, 0, 4, 1, 5, 2};
    a_tab  = '{1, 2, 3, 2, 0, 3};
    exp_tab = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 10 + i, 1, f3_tab[i], 32'h0000_1000 + a_tab[i], 32'h80FF_7F01, 32'd0);
      tick();
      n_tests++;
      if (writedata !== exp_tab[i] || regwrite !== 1'b1) begin
        n_fail++;
        $display("FAIL load%0d: f3=%0d a=%0d wd=%h rw=%b, required %h 1", i, f3_tab[i], a_tab[i], writedata, regwrite, exp_tab[i]);
      end
    end
    bubble();
    tick();
  endtask

  task automatic test_x0_jal();
    logic [63:0] base;
    base = instret;
    drive(1'b1, 1'b1, 0, 0, 0, 32'hDEAD_BEEF, 32'd0, 32'd0);
    tick();
    n_tests++;
    if (regwrite !== 1'b0 || wb_valid !== 1'b1 || writedata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL x0: rw=%b v=%b wd=%h, required 0 1 deadbeef", regwrite, wb_valid, writedata);
    end
    drive(1'b1, 1'b1, 1, 2, 0, 32'h1234_5678, 32'd0, 32'h0000_0104);
    tick();
    n_tests++;
    if (writedata !== 32'h104 || rd !== 5'd1 || regwrite !== 1'b1 || instret !== base + 64'd1) begin
      n_fail++;
      $display("FAIL jal: wd=%h rd=%0d rw=%b ir=%0d, required 104 1 1 %0d", writedata, rd, regwrite, instret, base + 64'd1);
    end
    bubble();
    tick();
  endtask

  task automatic test_stall();
    logic [63:0] base;
    drive(1'b1, 1'b1, 7, 0, 0, 32'h0000_0055, 32'd0, 32'd0);
    tick();
    base = instret;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 20 + i, 2, 0, $urandom, $urandom, $urandom);
      flush_i = (i == 1);
      tick();
      n_tests++;
      if (rd !== 5'd7 || writedata !== 32'h55 || regwrite !== 1'b1 || instret !== base) begin
        n_fail++;
        $display("FAIL stall%0d: rd=%0d wd=%h rw=%b ir=%0d, required 7 55 1 %0d", i, rd, writedata, regwrite, instret, base);
      end
    end
    stall_i = 1'b0; flush_i = 1'b0;
    bubble();
    tick();
    tick();
    n_tests++;
    if (instret !== base + 64'd1 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: ir=%0d v=%b, required %0d 0", instret, wb_valid, base + 64'd1);
    end
  endtask

  task automatic test_flush();
    logic [63:0] base;
    base = instret;
    drive(1'b1, 1'b1, 3, 0, 0, 32'h0000_0AAA, 32'd0, 32'd0);
    tick();
    drive(1'b1, 1'b1, 4, 0, 0, 32'h0000_0BBB, 32'd0, 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b0 || regwrite !== 1'b0 || instret !== base + 64'd1) begin
      n_fail++;
      $display("FAIL flush: v=%b rw=%b ir=%0d, required 0 0 %0d", wb_valid, regwrite, instret, base + 64'd1);
    end
    bubble();
    tick();
    tick();
    n_tests++;
    if (instret !== base + 64'd1) begin
      n_fail++;
      $display("FAIL flush_count: ir=%0d, required %0d", instret, base + 64'd1);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom, $urandom, $urandom);
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      tick();
      n_tests++;
      if (rd !== 5'(m_rd) || writedata !== m_wd || wb_valid !== m_valid ||
          regwrite !== (m_valid && m_rw && m_rd != 0) || instret !== m_instret) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random%0d: rd=%0d wd=%h rw=%b v=%b ir=%0d, required %0d %h %b %b %0d", i,
                   rd, writedata, regwrite, wb_valid, instret, m_rd, m_wd,
                   m_valid && m_rw && m_rd != 0, m_valid, m_instret);
      end
    end
    stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 9, 0, 0, 32'h100 + i, 32'd0, 32'd0);
      tick();
    end
    n_tests++;
    if (instret !== 64'd7 || regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: ir=%0d rw=%b, required 7 1", instret, regwrite);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rd !== 5'd0 || writedata !== 32'd0 || regwrite !== 1'b0 || wb_valid !== 1'b0 || instret !== 64'd0) begin
      n_fail++;
      $display("FAIL areset: rd=%0d wd=%h rw=%b v=%b ir=%0d, required all zero", rd, writedata, regwrite, wb_valid, instret);
    end
    apply_reset();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    test_reset();
    test_alu();
    test_loads();
    test_x0_jal();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32I pipeline. Registers the MEM/WB pipeline fields on posedge clk.
- Performs load-data extraction and result selection.
- Drives the register file write port (rd, writedata, regwrite) from registered state, so values are stable before the register file's negedge write.
- Also maintains the 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  pipeline clock; state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold WB register contents this cycle.
- flush_i  input  1  squash the incoming MEM instruction.
- mem_valid_i  input  1  MEM stage holds a real instruction.
- mem_regwrite_i  input  1  instruction writes rd.
- mem_rd_i  input  5  destination register index.
- mem_wbsel_i  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- mem_funct3_i  input  3  load type.
- mem_alu_result_i  input  32  ALU result / effective address.
- mem_rdata_i  input  32  aligned data-memory word.
- mem_pc4_i  input  32  PC+4 for JAL/JALR.
- rd  output  5  register file write index.
- writedata  output  32  register file write data.
- regwrite  output  1  register file write enable.
- wb_valid  output  1  WB register holds a real instruction.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0, asynchronous): wb_valid=0, all captured fields=0, instret=0. Consequently rd=0, writedata=0, regwrite=0.
- Mid-operation reset discards the held instruction with no retire count.
- Posedge clk, stall_i=0:
  - Capture all mem_* fields.
  - Set wb_valid to mem_valid_i & ~flush_i.
- Posedge clk, stall_i=1: all WB state holds. flush_i is ignored (stall has priority).
- Latency: one cycle from MEM inputs to rd/writedata/regwrite. The outputs are combinational from the WB register only, never from the mem_* inputs.
- regwrite = wb_valid & wb_regwrite & (wb_rd != 0). Writes to x0 are always suppressed.
- While stalled, regwrite stays asserted. The repeated register file write is idempotent and permitted.
- writedata select:
  - wbsel 00/11: alu_result.
  - wbsel 10: pc4.
  - wbsel 01: load result.
- Load extraction uses a = alu_result[1:0]:
  - funct3 000 LB: byte lane a, sign-extended.
  - 100 LBU: byte lane a, zero-extended.
  - 001 LH: halfword lane a[1], sign-extended; a[0] ignored.
  - 101 LHU: halfword lane a[1], zero-extended; a[0] ignored.
  - 010 LW and 011/110/111: full rdata; a ignored.
  - Lane mapping is little-endian: byte 0 = rdata[7:0].
- rd output equals wb_rd regardless of wb_valid. Consumers must qualify with regwrite.
- instret increments by 1 on each posedge where stall_i=0 and wb_valid=1 (the held instruction retires as it is replaced).
  - Bubbles and stalled cycles do not count.
  - instret wraps modulo 2^CNT_W without flagging.
- Flush with stall_i=0: the captured bubble has wb_valid=0. The WB instruction present in that same cycle still retires and is counted.

Test Plan:
- Reset, then MEM ALU op (rd=5, alu=0x0000_1234, regwrite=1, valid=1) → next cycle: rd=5, writedata=0x1234, regwrite=1. instret=1 one cycle later, after the op is replaced.
- Load, rdata=0x80FF_7F01: LB a=1 → 0x0000_007F; LB a=2 → 0xFFFF_FFFF; LBU a=3 → 0x0000_0080; LH a=2 → 0xFFFF_80FF; LHU a=0 → 0x0000_7F01; LW a=3 → 0x80FF_7F01.
- rd=0, regwrite=1, alu=0xDEAD_BEEF → regwrite=0, wb_valid=1, instret still increments. JAL with wbsel=10, pc4=0x0000_0104, rd=1 → writedata=0x104.
- Hold an ALU op with stall_i=1 for 3 cycles while the mem_* inputs change → outputs unchanged, regwrite held at 1. instret increments exactly once after stall drops.
- Assert flush_i=1 with a valid MEM op and stall_i=0 → next cycle wb_valid=0, regwrite=0. The previous WB instruction is counted; the flushed one is never counted.
- Assert rst_n=0 asynchronously mid-cycle with regwrite=1 and instret=7 → outputs are 0 immediately without waiting for a clock edge; instret=0.
